muxn_pipe: RTL and testbench
============================

MUXN_PIPE -- requirements
Module: muxn_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data width of each input and of the output.
REQ-002 Parameter N, default 4, number of input channels; legal range 2..16.
REQ-003 Parameter SELW, default $clog2(N), select width; derived, not overridden.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_data  input  N*WIDTH  packed channels; channel i occupies bits [i*WIDTH +: WIDTH].
REQ-007 in_sel  input  SELW  channel index, sampled with in_data on accept.
REQ-008 in_valid  input  1  upstream offers in_data/in_sel.
REQ-009 in_ready  output  1  block can accept this cycle.
REQ-010 out_data  output  WIDTH  selected channel, registered.
REQ-011 out_sel  output  SELW  in_sel that produced out_data.
REQ-012 out_err  output  1  in_sel was >= N for this beat.
REQ-013 out_valid  output  1  out_data/out_sel/out_err valid.
REQ-014 out_ready  input  1  downstream accepts this cycle.

Function
REQ-015 Accept occurs on a rising edge with in_valid=1 and in_ready=1; transfer occurs on a rising edge with out_valid=1 and out_ready=1.
REQ-016 Selection is direct: in_sel=i selects channel i (no inverted polarity).
REQ-017 in_sel >= N selects channel 0 and sets out_err=1 for that beat; otherwise out_err=0.
REQ-018 Latency is one cycle: a beat accepted at edge k is presented on out_* after edge k if the output register is empty or drains at edge k.
REQ-019 Storage is a 2-entry skid buffer: main register (drives out_*) and skid register.
REQ-020 States: EMPTY (0 beats), ONE (main full), TWO (main and skid full).
REQ-021 EMPTY: accept -> ONE, main loads.
REQ-022 ONE: accept without transfer -> TWO, skid loads; transfer without accept -> EMPTY; both -> ONE, main loads new beat; neither -> ONE.
REQ-023 TWO: transfer -> ONE, main loads skid contents; no transfer -> TWO.
REQ-024 in_ready SHALL be a register output, 1 in EMPTY and ONE, 0 in TWO; no combinational path from out_ready to in_ready.
REQ-025 While out_valid=1 and out_ready=0, out_data, out_sel and out_err SHALL hold stable.
REQ-026 Beats leave in acceptance order; none dropped or duplicated; sustained throughput one beat per cycle when out_ready=1.
REQ-027 in_data and in_sel are ignored when no accept occurs.

Reset
REQ-028 rst_n low SHALL immediately force state EMPTY, out_valid=0, out_data=0, out_sel=0, out_err=0, in_ready=0, skid register cleared.
REQ-029 in_ready SHALL rise on the first rising edge after rst_n deasserts.
REQ-030 Reset asserted mid-operation discards all held beats; no beat is presented after reset release until a new accept.

Structure
REQ-031 Shared package holds the state enumeration typedef (EMPTY/ONE/TWO) and the default data-width constant XLEN=32.
REQ-032 The combinational N:1 selection SHALL be a sub-module muxn_sel (parameters WIDTH, N; outputs selected data and error flag), instantiated once on the input side.

Verification
REQ-033 Reset: rst_n low mid-stream with 2 beats held -> out_valid=0, out_data=0, in_ready=0 immediately; in_ready=1 one edge after release.
REQ-034 Streaming: N=4, channels 0xA0..0xA3, in_sel 0,1,2,3 back-to-back, out_ready=1 -> out_data 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, one cycle latency.
REQ-035 Backpressure: out_ready=0, offer 3 beats -> 2 accepted, in_ready=0 after second, out_data holds first beat; raise out_ready -> beats emerge in order, third accepted after in_ready returns to 1.
REQ-036 Out-of-range: N=3, in_sel=3, channel 0=0x1234 -> out_data=0x1234, out_err=1, out_sel=3.
REQ-037 Simultaneous: state ONE, accept and transfer on same edge -> state stays ONE, out_data updates to new beat, no beat lost.
REQ-038 Random: random in_valid/out_ready over 10000 cycles, WIDTH=8 and WIDTH=64 -> scoreboard order match, no drops, stability rule REQ-025 never violated.

Source files
------------

// File: rtl/muxn_pipe_pkg.sv
// Shared definitions for the muxn_pipe block: the skid-buffer occupancy
// states and the default data width.
package muxn_pipe_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

endpackage

// File: rtl/muxn_sel.sv
// Combinational N:1 channel selector. An index at or above N falls back to
// channel 0 and raises the error flag.
module muxn_sel
  import muxn_pipe_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   sel_data,
  output logic               sel_err
);

  always_comb begin
    sel_err  = (int'(sel) >= N);
    sel_data = in_data[WIDTH-1:0];
    for (int i = 1; i < N; i++) begin
      if (int'(sel) == i) begin
        sel_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/muxn_pipe.sv
// Registered N:1 multiplexer behind a valid/ready handshake. A two-entry skid
// buffer keeps in_ready a pure flop output while sustaining one beat per cycle.
module muxn_pipe
  import muxn_pipe_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel,
  output logic               out_err,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [WIDTH-1:0] mux_data;
  logic             mux_err;

  muxn_sel #(
    .WIDTH (WIDTH),
    .N     (N),
    .SELW  (SELW)
  ) u_sel (
    .in_data  (in_data),
    .sel      (in_sel),
    .sel_data (mux_data),
    .sel_err  (mux_err)
  );

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [SELW-1:0]  main_sel_q, main_sel_d;
  logic             main_err_q, main_err_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic [SELW-1:0]  skid_sel_q, skid_sel_d;
  logic             skid_err_q, skid_err_d;

  logic accept;
  logic xfer;

  assign accept = in_valid & in_ready_q;
  assign xfer   = (state_q != ST_EMPTY) & out_ready;

  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_sel_d  = main_sel_q;
    main_err_d  = main_err_q;
    skid_data_d = skid_data_q;
    skid_sel_d  = skid_sel_q;
    skid_err_d  = skid_err_q;

    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          state_d     = ST_ONE;
          main_data_d = mux_data;
          main_sel_d  = in_sel;
          main_err_d  = mux_err;
        end
      end
      ST_ONE: begin
        if (accept && !xfer) begin
          state_d     = ST_TWO;
          skid_data_d = mux_data;
          skid_sel_d  = in_sel;
          skid_err_d  = mux_err;
        end else if (accept && xfer) begin
          main_data_d = mux_data;
          main_sel_d  = in_sel;
          main_err_d  = mux_err;
        end else if (xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        // in_ready is low here, so the only event is the main beat draining
        if (xfer) begin
          state_d     = ST_ONE;
          main_data_d = skid_data_q;
          main_sel_d  = skid_sel_q;
          main_err_d  = skid_err_q;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    in_ready_d = (state_d != ST_TWO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b0;
      main_data_q <= '0;
      main_sel_q  <= '0;
      main_err_q  <= 1'b0;
      skid_data_q <= '0;
      skid_sel_q  <= '0;
      skid_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_data_q <= main_data_d;
      main_sel_q  <= main_sel_d;
      main_err_q  <= main_err_d;
      skid_data_q <= skid_data_d;
      skid_sel_q  <= skid_sel_d;
      skid_err_q  <= skid_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_data_q;
  assign out_sel   = main_sel_q;
  assign out_err   = main_err_q;

endmodule

// File: tb/tb_muxn_pipe.sv
// Bench for muxn_pipe: a WIDTH=8/N=4 instance and a WIDTH=64/N=3 instance,
// directed handshake scenarios plus a random run against per-instance scoreboards.
module tb_muxn_pipe;

  logic clk;
  logic rst_n;

  logic [31:0]  i4_data;
  logic [1:0]   i4_sel;
  logic         i4_valid;
  logic         i4_ready;
  logic [7:0]   o4_data;
  logic [1:0]   o4_sel;
  logic         o4_err;
  logic         o4_valid;
  logic         o4_ready;

  logic [191:0] i3_data;
  logic [1:0]   i3_sel;
  logic         i3_valid;
  logic         i3_ready;
  logic [63:0]  o3_data;
  logic [1:0]   o3_sel;
  logic         o3_err;
  logic         o3_valid;
  logic         o3_ready;

  muxn_pipe #(.WIDTH(8), .N(4)) dut4 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (i4_data),
    .in_sel    (i4_sel),
    .in_valid  (i4_valid),
    .in_ready  (i4_ready),
    .out_data  (o4_data),
    .out_sel   (o4_sel),
    .out_err   (o4_err),
    .out_valid (o4_valid),
    .out_ready (o4_ready)
  );

  muxn_pipe #(.WIDTH(64), .N(3)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (i3_data),
    .in_sel    (i3_sel),
    .in_valid  (i3_valid),
    .in_ready  (i3_ready),
    .out_data  (o3_data),
    .out_sel   (o3_sel),
    .out_err   (o3_err),
    .out_valid (o3_valid),
    .out_ready (o3_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [3:0]  sel;
    logic        err;
  } beat_t;

  beat_t q4[$];
  beat_t q3[$];

  int vec_count = 0;
  int err_count = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vec_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic beat_t model_beat(input logic [255:0] d, input int sel, input int n, input int w);
    beat_t b;
    int    ch;
    ch     = (sel < n) ? sel : 0;
    b.data = '0;
    for (int k = 0; k < w; k++) b.data[k] = d[ch*w + k];
    b.sel  = 4'(sel);
    b.err  = (sel >= n);
    return b;
  endfunction

  task automatic applyStimulus(input logic v, input logic [1:0] s, input logic [31:0] d, input logic r);
    i4_valid = v;
    i4_sel   = s;
    i4_data  = d;
    o4_ready = r;
  endtask

  // Negedge monitors: stability of held outputs, then scoreboard pop/push
  logic       hold4_q;
  logic [7:0] hold4_data_q;
  logic [1:0] hold4_sel_q;
  logic       hold4_err_q;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold4_q <= 1'b0;
    end else begin
      if (hold4_q) begin
        checkOutput("hold4_valid", 64'(o4_valid), 64'd1);
        checkOutput("hold4_data", 64'(o4_data), 64'(hold4_data_q));
        checkOutput("hold4_sel", 64'(o4_sel), 64'(hold4_sel_q));
        checkOutput("hold4_err", 64'(o4_err), 64'(hold4_err_q));
      end
      hold4_q      <= o4_valid && !o4_ready;
      hold4_data_q <= o4_data;
      hold4_sel_q  <= o4_sel;
      hold4_err_q  <= o4_err;
      if (o4_valid && o4_ready) begin
        if (q4.size() == 0) begin
          checkOutput("sb4_pending", 64'(q4.size()), 64'd1);
        end else begin
          checkOutput("sb4_data", 64'(o4_data), q4[0].data);
          checkOutput("sb4_sel", 64'(o4_sel), 64'(q4[0].sel));
          checkOutput("sb4_err", 64'(o4_err), 64'(q4[0].err));
          void'(q4.pop_front());
        end
      end
      if (i4_valid && i4_ready) q4.push_back(model_beat({224'b0, i4_data}, int'(i4_sel), 4, 8));
    end
  end

  logic        hold3_q;
  logic [63:0] hold3_data_q;
  logic [1:0]  hold3_sel_q;
  logic        hold3_err_q;

  always @(negedge clk) begin
    if (!rst_n) begin
      hold3_q <= 1'b0;
    end else begin
      if (hold3_q) begin
        checkOutput("hold3_valid", 64'(o3_valid), 64'd1);
        checkOutput("hold3_data", o3_data, hold3_data_q);
        checkOutput("hold3_sel", 64'(o3_sel), 64'(hold3_sel_q));
        checkOutput("hold3_err", 64'(o3_err), 64'(hold3_err_q));
      end
      hold3_q      <= o3_valid && !o3_ready;
      hold3_data_q <= o3_data;
      hold3_sel_q  <= o3_sel;
      hold3_err_q  <= o3_err;
      if (o3_valid && o3_ready) begin
        if (q3.size() == 0) begin
          checkOutput("sb3_pending", 64'(q3.size()), 64'd1);
        end else begin
          checkOutput("sb3_data", o3_data, q3[0].data);
          checkOutput("sb3_sel", 64'(o3_sel), 64'(q3[0].sel));
          checkOutput("sb3_err", 64'(o3_err), 64'(q3[0].err));
          void'(q3.pop_front());
        end
      end
      if (i3_valid && i3_ready) q3.push_back(model_beat({64'b0, i3_data}, int'(i3_sel), 3, 64));
    end
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b0);
    i3_valid = 1'b0;
    i3_sel   = 2'd0;
    i3_data  = '0;
    o3_ready = 1'b0;

    #1;
    checkOutput("rst_valid4", 64'(o4_valid), 64'd0);
    checkOutput("rst_data4", 64'(o4_data), 64'd0);
    checkOutput("rst_ready4", 64'(i4_ready), 64'd0);
    checkOutput("rst_valid3", 64'(o3_valid), 64'd0);
    checkOutput("rst_ready3", 64'(i3_ready), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("rel_ready_low", 64'(i4_ready), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("rel_ready_high4", 64'(i4_ready), 64'd1);
    checkOutput("rel_ready_high3", 64'(i3_ready), 64'd1);

    $display("[TB] streaming");
    applyStimulus(1'b1, 2'd0, 32'hA3A2A1A0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("stream_valid%0d", k), 64'(o4_valid), 64'd1);
      checkOutput($sformatf("stream_data%0d", k), 64'(o4_data), 64'(8'hA0 + k));
      checkOutput($sformatf("stream_sel%0d", k), 64'(o4_sel), 64'(k));
      if (k < 3) i4_sel = 2'(k + 1);
      else       i4_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    checkOutput("stream_idle", 64'(o4_valid), 64'd0);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 2'd1, 32'h44332211, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("bp_first_valid", 64'(o4_valid), 64'd1);
    checkOutput("bp_first_data", 64'(o4_data), 64'h22);
    checkOutput("bp_first_ready", 64'(i4_ready), 64'd1);
    i4_sel = 2'd2;
    @(posedge clk);
    #1;
    checkOutput("bp_full_ready", 64'(i4_ready), 64'd0);
    checkOutput("bp_full_data", 64'(o4_data), 64'h22);
    i4_sel = 2'd3;
    @(posedge clk);
    #1;
    checkOutput("bp_stall_ready", 64'(i4_ready), 64'd0);
    checkOutput("bp_stall_data", 64'(o4_data), 64'h22);
    checkOutput("bp_stall_sel", 64'(o4_sel), 64'd1);
    o4_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_drain_data", 64'(o4_data), 64'h33);
    checkOutput("bp_drain_ready", 64'(i4_ready), 64'd1);
    @(posedge clk);
    #1;
    checkOutput("simul_valid", 64'(o4_valid), 64'd1);
    checkOutput("simul_data", 64'(o4_data), 64'h44);
    checkOutput("simul_ready", 64'(i4_ready), 64'd1);
    i4_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("bp_empty", 64'(o4_valid), 64'd0);

    $display("[TB] out of range");
    i3_data  = {64'hC2C2, 64'hC1C1, 64'h1234};
    i3_sel   = 2'd3;
    i3_valid = 1'b1;
    o3_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("oor_data", o3_data, 64'h1234);
    checkOutput("oor_err", 64'(o3_err), 64'd1);
    checkOutput("oor_sel", 64'(o3_sel), 64'd3);
    i3_sel = 2'd2;
    @(posedge clk);
    #1;
    checkOutput("inr_data", o3_data, 64'hC2C2);
    checkOutput("inr_err", 64'(o3_err), 64'd0);
    i3_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("oor_idle", 64'(o3_valid), 64'd0);

    $display("[TB] random traffic");
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      #1;
      applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom(),
                    $urandom_range(0, 2) != 0);
      i3_valid = ($urandom_range(0, 3) != 0);
      i3_sel   = 2'($urandom_range(0, 3));
      i3_data  = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      o3_ready = ($urandom_range(0, 2) != 0);
    end
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b1);
    i3_valid = 1'b0;
    o3_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("sb4_drained", 64'(q4.size()), 64'd0);
    checkOutput("sb3_drained", 64'(q3.size()), 64'd0);

    $display("[TB] reset with two beats held");
    applyStimulus(1'b1, 2'd1, 32'h5A6B7C8D, 1'b0);
    @(posedge clk);
    #1 i4_sel = 2'd2;
    @(posedge clk);
    #1 i4_valid = 1'b0;
    checkOutput("pre_rst_ready", 64'(i4_ready), 64'd0);
    checkOutput("pre_rst_data", 64'(o4_data), 64'h7C);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 64'(o4_valid), 64'd0);
    checkOutput("mid_rst_data", 64'(o4_data), 64'd0);
    checkOutput("mid_rst_sel", 64'(o4_sel), 64'd0);
    checkOutput("mid_rst_ready", 64'(i4_ready), 64'd0);
    q4.delete();
    q3.delete();
    o4_ready = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("post_rel_ready_low", 64'(i4_ready), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("post_rel_ready_high", 64'(i4_ready), 64'd1);
    checkOutput("post_rel_valid", 64'(o4_valid), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("post_rel_still_empty", 64'(o4_valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
